apb_uart_rx_periph: RTL

APB3 slave peripheral that receives 8N1 serial data on `rx` and buffers bytes in a small RX FIFO. Software drains received bytes over APB. It is the receive-direction companion of the team's APB UART transmit peripheral and sits on the same APB bus segment. It has its own 16x-oversampling baud tick, a start/stop-bit checker, sticky error flags and a level interrupt.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_fifo.sv | 75 +++++++
 rtl/apb_uart_rx_periph.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// uart_rx_pkg : shared types and constants for the APB UART receive peripheral
// Rev 1.0
// ============================================================================
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_RXDATA = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_FERR  = 2;
    localparam int STAT_OVR   = 3;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 8;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : small synchronous FIFO with registered full/empty flags
// Rev 1.0
// ============================================================================
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic               r_full;
    logic               r_empty;

    logic               w_do_pop;
    logic               w_do_push;
    logic [FIFO_AW-1:0] w_wr_next;
    logic [FIFO_AW-1:0] w_rd_next;

    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign w_do_pop  = i_pop & ~r_empty;
    assign w_do_push = i_push & (~r_full | w_do_pop);
    assign w_wr_next = r_wr_ptr + 1'b1;
    assign w_rd_next = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_do_push && !w_do_pop) begin
                r_empty <= 1'b0;
                r_full  <= (w_wr_next == r_rd_ptr);
            end else if (w_do_pop && !w_do_push) begin
                r_full  <= 1'b0;
                r_empty <= (w_rd_next == r_wr_ptr);
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/apb_uart_rx_periph.sv
`default_nettype none
// ============================================================================
// apb_uart_rx_periph : APB3 slave receiving 8N1 serial bytes into an RX FIFO
// Rev 1.0
// ============================================================================
module apb_uart_rx_periph
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 9600,
    parameter int FIFO_AW = 2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx,
    output logic        rx_irq
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       c_TICK_MID  = 4'(MID_START - 1);
    localparam logic [3:0]       c_TICK_LAST = 4'(OVERSAMPLE - 1);

    logic        r_pready;
    logic [31:0] r_prdata;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [DIV_W-1:0] r_div_cnt;
    rx_state_e   r_state;
    rx_state_e   w_state_n;
    logic [3:0]  r_tick_cnt;
    logic [3:0]  w_tick_cnt_n;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_n;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_n;
    logic        r_frame_err;
    logic        r_overrun;
    logic        r_rx_en;
    logic        r_irq_en;
    logic        r_irq;

    logic        w_tick;
    logic        w_fire;
    logic        w_rd_fire;
    logic        w_wr_fire;
    logic        w_push_req;
    logic        w_ferr_set;
    logic        w_ovr_set;
    logic        w_pop_req;
    logic        w_w1c_ferr;
    logic        w_w1c_ovr;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = ^{PWDATA[31:4], PADDR[1:0]};

    // ------------------------------------------------------------------ APB
    assign w_fire    = PSEL & PENABLE & ~r_pready;
    assign w_rd_fire = w_fire & ~PWRITE;
    assign w_wr_fire = w_fire & PWRITE;

    assign w_pop_req  = w_rd_fire & (PADDR[3:2] == ADDR_RXDATA) & ~w_empty;
    assign w_w1c_ferr = w_wr_fire & (PADDR[3:2] == ADDR_STATUS) & PWDATA[STAT_FERR];
    assign w_w1c_ovr  = w_wr_fire & (PADDR[3:2] == ADDR_STATUS) & PWDATA[STAT_OVR];
    assign w_ovr_set  = w_push_req & w_full & ~w_pop_req;

    always_comb begin
        w_rdata = '0;
        case (PADDR[3:2])
            ADDR_STATUS: begin
                w_rdata[STAT_EMPTY] = w_empty;
                w_rdata[STAT_FULL]  = w_full;
                w_rdata[STAT_FERR]  = r_frame_err;
                w_rdata[STAT_OVR]   = r_overrun;
            end
            ADDR_RXDATA: w_rdata[7:0] = w_empty ? 8'h00 : w_head;
            ADDR_CTRL:   w_rdata[1:0] = {r_irq_en, r_rx_en};
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_pready    <= 1'b0;
            r_prdata    <= '0;
            r_rx_en     <= 1'b0;
            r_irq_en    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_pready <= w_fire;
            if (w_rd_fire) begin
                r_prdata <= w_rdata;
            end
            if (w_wr_fire && (PADDR[3:2] == ADDR_CTRL)) begin
                r_rx_en  <= PWDATA[0];
                r_irq_en <= PWDATA[1];
            end
            // A set event in the same cycle as its W1C leaves the flag set.
            r_frame_err <= w_ferr_set | (r_frame_err & ~w_w1c_ferr);
            r_overrun   <= w_ovr_set  | (r_overrun   & ~w_w1c_ovr);
            r_irq       <= r_irq_en & (~w_empty | r_frame_err | r_overrun);
        end
    end

    assign PREADY = r_pready;
    assign PRDATA = r_prdata;
    assign rx_irq = r_irq;

    // ------------------------------------------------- sync and baud tick
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_div_cnt <= '0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            if (!r_rx_en || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign w_tick = r_rx_en & (r_div_cnt == c_DIV_LAST);

    // ------------------------------------------------------- receiver FSM
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_tick_cnt <= w_tick_cnt_n;
            r_bit_idx  <= w_bit_idx_n;
            r_shift    <= w_shift_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_tick_cnt_n = r_tick_cnt;
        w_bit_idx_n  = r_bit_idx;
        w_shift_n    = r_shift;
        w_push_req   = 1'b0;
        w_ferr_set   = 1'b0;
        if (!r_rx_en) begin
            w_state_n    = IDLE;
            w_tick_cnt_n = '0;
            w_bit_idx_n  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_sync) begin
                        w_state_n    = START;
                        w_tick_cnt_n = '0;
                        w_bit_idx_n  = '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_TICK_MID) begin
                            w_tick_cnt_n = '0;
                            w_state_n    = r_rx_sync ? IDLE : DATA;
                        end else begin
                            w_tick_cnt_n = r_tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_TICK_LAST) begin
                            w_tick_cnt_n         = '0;
                            w_shift_n[r_bit_idx] = r_rx_sync;
                            if (r_bit_idx == 3'd7) begin
                                w_state_n = STOP;
                            end else begin
                                w_bit_idx_n = r_bit_idx + 1'b1;
                            end
                        end else begin
                            w_tick_cnt_n = r_tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_TICK_LAST) begin
                            w_tick_cnt_n = '0;
                            w_state_n    = IDLE;
                            w_push_req   = r_rx_sync;
                            w_ferr_set   = ~r_rx_sync;
                        end else begin
                            w_tick_cnt_n = r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .FIFO_AW (FIFO_AW),
        .DATA_W  (8)
    ) u_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_push  (w_push_req),
        .i_pop   (w_pop_req),
        .i_data  (r_shift),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire
